stopwatch_counter_core: RTL and testbench

STOPWATCH_COUNTER_CORE -- requirements
Module: stopwatch_counter_core

---
 rtl/stopwatch_counter_core.sv | 259 +++++++++++++++++++++++++
 tb/tb_stopwatch_counter_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter_core.sv
// ----------------------------------------------------------------------------
// stopwatch_counter_core
//
// Purpose:
//   MM:SS stopwatch counting core with BCD outputs. In normal mode it counts
//   seconds on tick_1hz while running, and the pause button toggles run/stop.
//   In adjust mode the pause button increments the selected field. Holding the
//   button auto-repeats on tick_2hz once HOLD_TICKS pulses have elapsed.
//
// Optional feature:
//   STOPWATCH_LAP_EN - adds lap_db. A lap edge freezes the displayed digits
//   while counting continues. The next lap edge releases them.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tick_1hz   in   single-cycle count enable
//   tick_2hz   in   single-cycle auto-repeat pulse
//   pause_db   in   debounced pause button level (1 = pressed)
//   adj_db     in   debounced adjust switch (1 = adjust mode)
//   sel_db     in   debounced select switch (1 = seconds, 0 = minutes)
//   lap_db     in   debounced lap button (STOPWATCH_LAP_EN only)
//   mt,mo      out  minutes tens / ones (BCD, registered)
//   st,so      out  seconds tens / ones (BCD, registered)
//   running    out  run/stop flag (held through adjust mode)
//   adj_field  out  00 none, 01 minutes, 10 seconds
// ----------------------------------------------------------------------------
module stopwatch_counter_core #(
  parameter int HOLD_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_db,
  input  logic       adj_db,
  input  logic       sel_db,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap_db,
`endif
  output logic [3:0] mt,
  output logic [3:0] mo,
  output logic [3:0] st,
  output logic [3:0] so,
  output logic       running,
  output logic [1:0] adj_field
);

  localparam int HW = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_TICKS);

  typedef enum logic [2:0] {
    NRM_STOP = 3'd0,
    NRM_RUN  = 3'd1,
    ADJ_IDLE = 3'd2,
    ADJ_WAIT = 3'd3,
    ADJ_RPT  = 3'd4
  } state_e;

  // Increment a two-digit BCD field in the range 00..59, wrapping 59 -> 00.
  function automatic logic [7:0] bcd59_inc(input logic [7:0] f);
    logic [7:0] r;
    if (f[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      if (f[7:4] >= 4'd5) begin
        r[7:4] = 4'd0;
      end else begin
        r[7:4] = f[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = f[3:0] + 4'd1;
      r[7:4] = f[7:4];
    end
    return r;
  endfunction

  state_e         state_q, state_d;
  logic           run_q, run_d;
  logic           pause_q;
  logic           hist_vld_q;   // edge history holds a real sample
  logic           sel_q;
  logic [HW-1:0]  hold_q, hold_d;
  logic [HW-1:0]  hold_inc_s;
  logic [7:0]     min_q, min_d;
  logic [7:0]     sec_q, sec_d;
  logic [1:0]     adj_field_q, adj_field_d;
  logic           press_s;
  logic           sel_chg_s;
  logic           adj_inc_s;

  // The history is only trusted after one post-reset sample. A button held
  // through reset therefore needs a release and a re-press to raise an event.
  assign press_s    = hist_vld_q & pause_db & ~pause_q;
  assign sel_chg_s  = sel_db ^ sel_q;
  assign hold_inc_s = hold_q + HW'(1);

  // Next-state, counting and adjust logic.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    hold_d      = hold_q;
    min_d       = min_q;
    sec_d       = sec_q;
    adj_inc_s   = 1'b0;
    adj_field_d = 2'b00;
    if (!adj_db) begin
      hold_d = '0;
      // The tick uses the pre-toggle run value, so a coincident press still counts.
      if (run_q && tick_1hz) begin
        sec_d = bcd59_inc(sec_q);
        if (sec_q == 8'h59) begin
          min_d = bcd59_inc(min_q);
        end else begin
          min_d = min_q;
        end
      end else begin
        sec_d = sec_q;
      end
      if (press_s) begin
        run_d = ~run_q;
      end else begin
        run_d = run_q;
      end
      state_d = run_d ? NRM_RUN : NRM_STOP;
    end else begin
      adj_field_d = sel_db ? 2'b10 : 2'b01;
      case (state_q)
        ADJ_WAIT: begin
          if (!pause_db) begin
            state_d = ADJ_IDLE;
            hold_d  = '0;
          end else if (sel_chg_s) begin
            hold_d  = '0;
          end else if (tick_2hz) begin
            hold_d = hold_inc_s;
            if (hold_inc_s >= HOLD_LIM) begin
              state_d = ADJ_RPT;
            end else begin
              state_d = ADJ_WAIT;
            end
          end else begin
            hold_d = hold_q;
          end
        end
        ADJ_RPT: begin
          if (!pause_db) begin
            state_d = ADJ_IDLE;
            hold_d  = '0;
          end else if (sel_chg_s) begin
            // Field switch restarts the hold delay before repeating again.
            state_d = ADJ_WAIT;
            hold_d  = '0;
          end else if (tick_2hz) begin
            adj_inc_s = 1'b1;
          end else begin
            adj_inc_s = 1'b0;
          end
        end
        default: begin
          // ADJ_IDLE, and the entry cycle from NRM_STOP / NRM_RUN.
          hold_d = '0;
          if (press_s) begin
            adj_inc_s = 1'b1;
            state_d   = ADJ_WAIT;
          end else begin
            state_d   = ADJ_IDLE;
          end
        end
      endcase
      // Adjust increments wrap within the field only, never carrying.
      if (adj_inc_s) begin
        if (sel_db) begin
          sec_d = bcd59_inc(sec_q);
        end else begin
          min_d = bcd59_inc(min_q);
        end
      end else begin
        sec_d = sec_q;
      end
    end
  end

  // State, counters and edge-history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= NRM_STOP;
      run_q       <= 1'b0;
      pause_q     <= 1'b0;
      hist_vld_q  <= 1'b0;
      sel_q       <= 1'b0;
      hold_q      <= '0;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      adj_field_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      pause_q     <= pause_db;
      hist_vld_q  <= 1'b1;
      sel_q       <= sel_db;
      hold_q      <= hold_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      adj_field_q <= adj_field_d;
    end
  end

  assign running   = run_q;
  assign adj_field = adj_field_q;

`ifdef STOPWATCH_LAP_EN
  logic        lap_q;
  logic        freeze_q, freeze_d;
  logic [15:0] disp_q;
  logic        lap_evt_s;

  assign lap_evt_s = hist_vld_q & lap_db & ~lap_q;

  // Lap freeze toggles on lap edges in normal mode; adjust mode is always live.
  always_comb begin
    freeze_d = freeze_q;
    if (adj_db) begin
      freeze_d = 1'b0;
    end else if (lap_evt_s) begin
      freeze_d = ~freeze_q;
    end else begin
      freeze_d = freeze_q;
    end
  end

  // Displayed digits track the live count unless frozen by a lap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q    <= 1'b0;
      freeze_q <= 1'b0;
      disp_q   <= 16'h0000;
    end else begin
      lap_q    <= lap_db;
      freeze_q <= freeze_d;
      if (!freeze_d) begin
        disp_q <= {min_d, sec_d};
      end else begin
        disp_q <= disp_q;
      end
    end
  end

  assign mt = disp_q[15:12];
  assign mo = disp_q[11:8];
  assign st = disp_q[7:4];
  assign so = disp_q[3:0];
`else
  assign mt = min_q[7:4];
  assign mo = min_q[3:0];
  assign st = sec_q[7:4];
  assign so = sec_q[3:0];
`endif

endmodule

// File: tb/tb_stopwatch_counter_core.sv
// ----------------------------------------------------------------------------
// tb_stopwatch_counter_core
//
// Directed self-checking bench for stopwatch_counter_core with the default
// HOLD_TICKS = 2. Inputs change on the falling edge, and outputs are checked on
// the falling edge that follows the rising edge which acts on them. Expected
// times are written as 16'hMMSS BCD constants.
// ----------------------------------------------------------------------------
module tb_stopwatch_counter_core;

  logic       clk;
  logic       rst_n;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       pause_db;
  logic       adj_db;
  logic       sel_db;
`ifdef STOPWATCH_LAP_EN
  logic       lap_db;
`endif
  logic [3:0] mt, mo, st, so;
  logic       running;
  logic [1:0] adj_field;

  int checks;
  int failures;

  stopwatch_counter_core #(.HOLD_TICKS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .tick_2hz  (tick_2hz),
    .pause_db  (pause_db),
    .adj_db    (adj_db),
    .sel_db    (sel_db),
`ifdef STOPWATCH_LAP_EN
    .lap_db    (lap_db),
`endif
    .mt        (mt),
    .mo        (mo),
    .st        (st),
    .so        (so),
    .running   (running),
    .adj_field (adj_field)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] disp();
    return {mt, mo, st, so};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic press();
    pause_db = 1'b1;
    cyc();
    pause_db = 1'b0;
    cyc();
  endtask

  task automatic press_n(input int n);
    for (int i = 0; i < n; i++) press();
  endtask

  task automatic t1();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    cyc();
  endtask

  task automatic t2();
    tick_2hz = 1'b1;
    cyc();
    tick_2hz = 1'b0;
    cyc();
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic lap();
    lap_db = 1'b1;
    cyc();
    lap_db = 1'b0;
    cyc();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    tick_1hz = 1'b0;
    tick_2hz = 1'b0;
    pause_db = 1'b0;
    adj_db   = 1'b0;
    sel_db   = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_db   = 1'b0;
`endif
    cyc(); cyc(); cyc();
    chk("reset_time", disp(), 16'h0000);
    chk("reset_running", running, 1'b0);
    chk("reset_adj_field", adj_field, 2'b00);
    rst_n = 1'b1;
    cyc();

    // Start and count five seconds.
    press();
    chk("press_starts", running, 1'b1);
    for (int i = 0; i < 5; i++) t1();
    chk("count_5", disp(), 16'h0005);
    chk("count_5_running", running, 1'b1);
    for (int i = 0; i < 5; i++) t1();
    chk("count_10_tens_carry", disp(), 16'h0010);

    // A press coincident with a tick: the tick still counts, then it stops.
    pause_db = 1'b1;
    tick_1hz = 1'b1;
    cyc();
    pause_db = 1'b0;
    tick_1hz = 1'b0;
    cyc();
    chk("coincident_time", disp(), 16'h0011);
    chk("coincident_stopped", running, 1'b0);
    t1();
    chk("stopped_no_count", disp(), 16'h0011);

    // Adjust minutes, then seconds with in-field wrap.
    adj_db = 1'b1;
    sel_db = 1'b0;
    cyc();
    chk("adj_field_min", adj_field, 2'b01);
    press_n(3);
    chk("adj_min_3", disp(), 16'h0311);
    sel_db = 1'b1;
    cyc();
    chk("adj_field_sec", adj_field, 2'b10);
    press_n(47);
    chk("adj_sec_58", disp(), 16'h0358);
    press();
    chk("adj_sec_59", disp(), 16'h0359);
    press();
    chk("adj_sec_wrap_no_carry", disp(), 16'h0300);
    t1();
    chk("adj_ignores_tick", disp(), 16'h0300);
    chk("adj_running_held", running, 1'b0);

    // Hold pause on minutes: one press increment, a two-tick delay, then repeats.
    sel_db = 1'b0;
    cyc();
    pause_db = 1'b1;
    cyc();
    chk("hold_press_inc", disp(), 16'h0400);
    t2(); t2();
    chk("hold_delay_no_repeat", disp(), 16'h0400);
    t2(); t2(); t2();
    chk("hold_3_repeats", disp(), 16'h0700);
    pause_db = 1'b0;
    cyc();
    t2(); t2(); t2();
    chk("release_no_repeat", disp(), 16'h0700);

    // Changing select while held restarts the delay on the new field.
    pause_db = 1'b1;
    cyc();
    chk("hold2_press_inc", disp(), 16'h0800);
    t2(); t2();
    sel_db = 1'b1;
    cyc();
    t2(); t2();
    chk("sel_change_delay", disp(), 16'h0800);
    t2();
    chk("sel_change_repeat_sec", disp(), 16'h0801);
    pause_db = 1'b0;
    cyc();

    // Preload 59:58, then count across the full wrap.
    sel_db = 1'b0;
    cyc();
    press_n(51);
    sel_db = 1'b1;
    cyc();
    press_n(57);
    chk("preload_5958", disp(), 16'h5958);
    adj_db = 1'b0;
    cyc();
    chk("exit_adj_field", adj_field, 2'b00);
    chk("exit_running_restored", running, 1'b0);
    press();
    chk("run_after_adj", running, 1'b1);
    t1();
    chk("count_5959", disp(), 16'h5959);
    t1();
    chk("wrap_0000", disp(), 16'h0000);

    // A running state survives a trip through adjust mode.
    adj_db = 1'b1;
    cyc();
    t1();
    chk("adj_running_kept", running, 1'b1);
    chk("adj_no_count_run", disp(), 16'h0000);
    adj_db = 1'b0;
    cyc();
    t1();
    chk("resume_count", disp(), 16'h0001);

`ifdef STOPWATCH_LAP_EN
    t1(); t1();
    chk("lap_pre_0003", disp(), 16'h0003);
    lap();
    for (int i = 0; i < 4; i++) t1();
    chk("lap_frozen", disp(), 16'h0003);
    lap();
    chk("lap_released", disp(), 16'h0007);
`endif

    // Asynchronous reset with pause held: no event until re-pressed.
    pause_db = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_time", disp(), 16'h0000);
    chk("async_reset_running", running, 1'b0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("held_through_reset", running, 1'b0);
    pause_db = 1'b0;
    cyc();
    chk("release_after_reset", running, 1'b0);
    press();
    chk("repress_after_reset", running, 1'b1);
    t1();
    chk("count_after_reset", disp(), 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
